// File: rtl/risc16b_core.sv
// risc16b_core: 3-stage (IF/ID/EX) 16-bit RISC core with write-back, full forwarding and byte-writable data port
module risc16b_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd1,
  output logic [15:0] rd2
);
  logic [15:0] registers [0:7];
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++) registers[i] <= '0;
    end else if (we) registers[wa] <= wd;
  assign rd1 = registers[ra1];
  assign rd2 = registers[ra2];
endmodule

module risc16b_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] i_addr,
  output logic        i_oe,
  input  logic [15:0] i_din,
  output logic [15:0] d_addr,
  output logic        d_oe,
  input  logic [15:0] d_din,
  output logic [15:0] d_dout,
  output logic [1:0]  d_we
);
  logic [15:0] if_pc, if_ir, id_ir, id_pc, id_operand_reg1, id_operand_reg2, id_imm_reg, ex_ir, ex_result_reg;
  logic [15:0] rf1, rf2, rv1, rv2, a, b, res, if_pc_bta;
  logic        wb_we, if_pc_we, r_form, is_st, is_ld, is_sbu, is_lbu;

  function automatic logic writes(input logic [15:0] ir);
    return ir[15:11] == 5'b00000
      ? ir[4:0] inside {5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01001,
                        5'b01100, 5'b01101, 5'b10000, 5'b10001, 5'b10101, 5'b10111}
      : ir[15:11] inside {5'b00001, 5'b00100, 5'b00101, 5'b00110, 5'b00111};
  endfunction

  assign wb_we = writes(ex_ir);

  risc16b_regfile reg_file_inst (
    .clk(clk), .rst(rst), .we(wb_we), .wa(ex_ir[10:8]), .wd(ex_result_reg),
    .ra1(if_ir[10:8]), .ra2(if_ir[7:5]), .rd1(rf1), .rd2(rf2)
  );

  // ID bypasses the write happening this cycle; EX forwards the previous EX result
  assign rv1 = wb_we && ex_ir[10:8] == if_ir[10:8] ? ex_result_reg : rf1;
  assign rv2 = wb_we && ex_ir[10:8] == if_ir[7:5] ? ex_result_reg : rf2;
  assign a = wb_we && ex_ir[10:8] == id_ir[10:8] ? ex_result_reg : id_operand_reg1;
  assign b = wb_we && ex_ir[10:8] == id_ir[7:5] ? ex_result_reg : id_operand_reg2;

  assign r_form = id_ir[15:11] == 5'b00000;
  assign is_st = r_form && id_ir[4:0] == 5'b10100;
  assign is_ld = r_form && id_ir[4:0] == 5'b10101;
  assign is_sbu = r_form && id_ir[4:0] == 5'b10110;
  assign is_lbu = r_form && id_ir[4:0] == 5'b10111;

  assign i_addr = if_pc;
  assign i_oe = ~rst;
  assign d_addr = is_st || is_ld ? {b[15:1], 1'b0} : is_sbu || is_lbu ? b : '0;
  assign d_oe = is_ld || is_lbu;
  assign d_we = rst ? 2'b00 : is_st ? 2'b11 : is_sbu ? (b[0] ? 2'b10 : 2'b01) : 2'b00;
  assign d_dout = is_st ? a : is_sbu ? {a[7:0], a[7:0]} : '0;
  assign if_pc_bta = id_pc + 16'd2 + (id_ir[15:11] == 5'b11000 ? {{5{id_ir[10]}}, id_ir[10:0]} : id_imm_reg);

  always_comb begin
    res = '0;
    if_pc_we = 1'b0;
    case (id_ir[15:11])
      5'b00000:
        case (id_ir[4:0])
          5'b00001: res = b;
          5'b00010: res = ~b;
          5'b00011: res = a ^ b;
          5'b00100: res = a + b;
          5'b00101: res = a - b;
          5'b01000: res = b << 8;
          5'b01001: res = b >> 8;
          5'b01100: res = b << 1;
          5'b01101: res = b >> 1;
          5'b10000: res = a & b;
          5'b10001: res = a | b;
          5'b10101: res = d_din;
          5'b10111: res = {8'h00, b[0] ? d_din[7:0] : d_din[15:8]};
          default: res = '0;
        endcase
      5'b00100: res = a + id_imm_reg;
      5'b00101: res = a & {8'h00, id_imm_reg[7:0]};
      5'b00110: res = a | {8'h00, id_imm_reg[7:0]};
      5'b00111: res = {8'h00, id_imm_reg[7:0]};
      5'b00001: res = {id_imm_reg[7:0], 8'h00};
      5'b10000: if_pc_we = |a;
      5'b10001: if_pc_we = ~|a;
      5'b10010: if_pc_we = a[15];
      5'b10011: if_pc_we = ~a[15];
      5'b11000: if_pc_we = 1'b1;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc <= RESET_PC;
      if_ir <= '0;
      id_ir <= '0;
      id_pc <= '0;
      id_operand_reg1 <= '0;
      id_operand_reg2 <= '0;
      id_imm_reg <= '0;
      ex_ir <= '0;
      ex_result_reg <= '0;
    end else begin
      if_pc <= if_pc_we ? if_pc_bta : if_pc + 16'd2;
      if_ir <= if_pc_we ? '0 : i_din;
      id_ir <= if_pc_we ? '0 : if_ir;
      id_pc <= if_pc - 16'd2;
      id_operand_reg1 <= rv1;
      id_operand_reg2 <= rv2;
      id_imm_reg <= {{8{if_ir[7]}}, if_ir[7:0]};
      ex_ir <= id_ir;
      ex_result_reg <= res;
    end
  end
endmodule

// File: tb/tb_risc16b_core.sv
// tb_risc16b_core: directed and random programs checked against an instruction-level reference model
module tb_risc16b_core;
  localparam logic [15:0] HALT = 16'hC7FE;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] i_addr, i_din, d_addr, d_din, d_dout;
  logic i_oe, d_oe;
  logic [1:0] d_we;
  logic [15:0] imem [0:32767];
  logic [7:0] dmem [0:65535];
  logic [7:0] mmem [0:65535];
  logic [15:0] mreg [0:7];
  logic [15:0] led, mled, mm_addr;
  logic [1:0] mm_we;
  int checks = 0;
  int errors = 0;

  risc16b_core dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_oe(i_oe), .i_din(i_din),
    .d_addr(d_addr), .d_oe(d_oe), .d_din(d_din), .d_dout(d_dout), .d_we(d_we)
  );

  always #5 clk = ~clk;
  assign i_din = imem[i_addr[15:1]];
  assign d_din = {dmem[{d_addr[15:1], 1'b0}], dmem[{d_addr[15:1], 1'b1}]};

  // 0x7Fxx is MMIO: writes never reach RAM, a word store to 0x7F00 updates the LED
  always @(posedge clk) begin
    if (rst) begin
      led = 16'h0000;
      mm_we = 2'b00;
      mm_addr = 16'h0000;
    end
    if (d_addr[15:8] == 8'h7F) begin
      if (d_we != 2'b00) begin
        mm_we = d_we;
        mm_addr = d_addr;
      end
      if (d_addr == 16'h7F00 && d_we == 2'b11) led = d_dout;
    end else begin
      if (d_we[0]) dmem[{d_addr[15:1], 1'b0}] = d_dout[15:8];
      if (d_we[1]) dmem[{d_addr[15:1], 1'b1}] = d_dout[7:0];
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [4:0] fn, input logic [2:0] rd, input logic [2:0] rs);
    return {5'b00000, rd, rs, fn};
  endfunction

  function automatic logic [15:0] fi(input logic [4:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  function automatic logic [15:0] reg_or();
    logic [15:0] acc = 16'h0000;
    for (int i = 0; i < 8; i++) acc |= dut.reg_file_inst.registers[i];
    return acc;
  endfunction

  function automatic logic [15:0] gen();
    logic [15:0] w;
    logic [2:0] rd = 3'($urandom);
    logic [7:0] im = 8'($urandom);
    case ($urandom_range(0, 12))
      0, 1, 2, 3: w = {5'd0, rd, 3'($urandom), 5'($urandom)};
      4: w = fi(5'd4, rd, im);
      5: w = fi(5'd5, rd, im);
      6: w = fi(5'd6, rd, im);
      7, 8: w = fi(5'd7, rd, im);
      9: w = fi(5'd1, rd, im);
      10: w = {5'(16 + $urandom_range(0, 3)), rd, 8'(2 * $urandom_range(0, 5))};
      11: w = {5'b11000, 11'(2 * $urandom_range(0, 5))};
      default: w = {5'($urandom_range(8, 15)), 11'($urandom)};
    endcase
    return w;
  endfunction

  // Executes the program one instruction at a time from address 0 until the halt self-loop
  task automatic run_model();
    logic [15:0] pc, ir, a, b, ea, sx;
    logic [2:0] rd, rs;
    pc = 16'h0000;
    mled = 16'h0000;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0000;
    for (int s = 0; s < 4000; s++) begin
      ir = imem[pc[15:1]];
      if (ir == HALT) break;
      rd = ir[10:8];
      rs = ir[7:5];
      a = mreg[rd];
      b = mreg[rs];
      ea = {b[15:1], 1'b0};
      sx = {{8{ir[7]}}, ir[7:0]};
      pc = pc + 16'd2;
      if (ir[15:11] == 5'd0) begin
        case (ir[4:0])
          5'd1: mreg[rd] = b;
          5'd2: mreg[rd] = ~b;
          5'd3: mreg[rd] = a ^ b;
          5'd4: mreg[rd] = a + b;
          5'd5: mreg[rd] = a - b;
          5'd8: mreg[rd] = b << 8;
          5'd9: mreg[rd] = b >> 8;
          5'd12: mreg[rd] = b << 1;
          5'd13: mreg[rd] = b >> 1;
          5'd16: mreg[rd] = a & b;
          5'd17: mreg[rd] = a | b;
          5'd20: if (ea == 16'h7F00) mled = a;
                 else if (ea[15:8] != 8'h7F) begin
                   mmem[ea] = a[15:8];
                   mmem[ea + 16'd1] = a[7:0];
                 end
          5'd21: mreg[rd] = {mmem[ea], mmem[ea + 16'd1]};
          5'd22: if (b[15:8] != 8'h7F) mmem[b] = a[7:0];
          5'd23: mreg[rd] = {8'h00, mmem[b]};
          default: ;
        endcase
      end else begin
        case (ir[15:11])
          5'd4: mreg[rd] = a + sx;
          5'd5: mreg[rd] = a & {8'h00, ir[7:0]};
          5'd6: mreg[rd] = a | {8'h00, ir[7:0]};
          5'd7: mreg[rd] = {8'h00, ir[7:0]};
          5'd1: mreg[rd] = {ir[7:0], 8'h00};
          5'd16: if (a != 16'h0000) pc = pc + sx;
          5'd17: if (a == 16'h0000) pc = pc + sx;
          5'd18: if (a[15]) pc = pc + sx;
          5'd19: if (!a[15]) pc = pc + sx;
          5'd24: pc = pc + {{5{ir[10]}}, ir[10:0]};
          default: ;
        endcase
      end
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] saved;
    logic [7:0] b0, b1;
    int diffs, found;
    for (int i = 0; i < 32768; i++) imem[i] = HALT;
    for (int i = 0; i < 65536; i++) dmem[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_i_oe", 16'(i_oe), 16'd0);
    check("rst_i_addr", i_addr, 16'h0000);
    check("rst_d_we", 16'(d_we), 16'd0);
    check("rst_d_oe", 16'(d_oe), 16'd0);
    check("rst_regs", reg_or(), 16'h0000);
    rst = 1'b0;
    #1;
    check("first_fetch", i_addr, 16'h0000);
    check("i_oe_run", 16'(i_oe), 16'd1);
    @(negedge clk);
    check("second_fetch", i_addr, 16'h0002);

    rst = 1'b1;
    imem[0] = fi(5'd7, 3'd1, 8'h12);
    imem[1] = fi(5'd1, 3'd2, 8'h34);
    imem[2] = rr(5'd4, 3'd2, 3'd1);
    imem[3] = fi(5'd7, 3'd3, 8'h80);
    imem[4] = rr(5'd20, 3'd2, 3'd3);
    imem[5] = rr(5'd21, 3'd4, 3'd3);
    imem[6] = rr(5'd4, 3'd4, 3'd4);
    imem[7] = fi(5'd4, 3'd3, 8'h01);
    imem[8] = rr(5'd22, 3'd1, 3'd3);
    imem[9] = fi(5'd4, 3'd3, 8'hFF);
    imem[10] = rr(5'd23, 3'd5, 3'd3);
    imem[11] = fi(5'd7, 3'd6, 8'h00);
    imem[12] = fi(5'd17, 3'd6, 8'h04);
    imem[13] = fi(5'd4, 3'd7, 8'h01);
    imem[14] = fi(5'd4, 3'd7, 8'h01);
    imem[15] = fi(5'd1, 3'd1, 8'h7F);
    imem[16] = fi(5'd7, 3'd2, 8'h5A);
    imem[17] = rr(5'd20, 3'd2, 3'd1);
    saved = {dmem[16'h7F00], dmem[16'h7F01]};
    release_reset();
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("dir_r1", dut.reg_file_inst.registers[1], 16'h7F00);
    check("dir_r2", dut.reg_file_inst.registers[2], 16'h005A);
    check("dir_r3", dut.reg_file_inst.registers[3], 16'h0080);
    check("dir_r4_ld_fwd", dut.reg_file_inst.registers[4], 16'h6824);
    check("dir_r5_lbu", dut.reg_file_inst.registers[5], 16'h0034);
    check("dir_r6", dut.reg_file_inst.registers[6], 16'h0000);
    check("dir_r7_squash", dut.reg_file_inst.registers[7], 16'h0000);
    check("dir_mem80", 16'(dmem[16'h0080]), 16'h0034);
    check("dir_mem81", 16'(dmem[16'h0081]), 16'h0012);
    check("dir_led", led, 16'h005A);
    check("dir_mmio_we", 16'(mm_we), 16'h0003);
    check("dir_mmio_addr", mm_addr, 16'h7F00);
    check("dir_mmio_ram", {dmem[16'h7F00], dmem[16'h7F01]}, saved);

    for (int p = 0; p < 8; p++) begin
      rst = 1'b1;
      for (int i = 0; i < 256; i++) imem[i] = HALT;
      for (int i = 0; i < 48; i++) imem[i] = gen();
      for (int i = 0; i < 65536; i++) begin
        dmem[i] = 8'($urandom);
        mmem[i] = dmem[i];
      end
      run_model();
      release_reset();
      repeat (48 * 3 + 20) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        check($sformatf("rnd%0d_r%0d", p, i), dut.reg_file_inst.registers[i], mreg[i]);
      diffs = 0;
      for (int i = 0; i < 65536; i++) if (dmem[i] !== mmem[i]) diffs++;
      check($sformatf("rnd%0d_mem_diffs", p), 16'(diffs), 16'd0);
      check($sformatf("rnd%0d_led", p), led, mled);
    end

    rst = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = HALT;
    imem[0] = fi(5'd4, 3'd1, 8'h01);
    imem[1] = rr(5'd20, 3'd1, 3'd2);
    imem[2] = {5'b11000, 11'h7FA};
    release_reset();
    found = 0;
    for (int c = 0; c < 60 && found == 0; c++) begin
      @(negedge clk);
      if (d_we == 2'b11) found = 1;
    end
    check("loop_store_seen", 16'(found), 16'd1);
    if (found != 0) begin
      b0 = dmem[0];
      b1 = dmem[1];
      rst = 1'b1;
      #1;
      check("mid_rst_d_we", 16'(d_we), 16'd0);
      check("mid_rst_i_oe", 16'(i_oe), 16'd0);
      @(negedge clk);
      check("mid_rst_pc", i_addr, 16'h0000);
      check("mid_rst_regs", reg_or(), 16'h0000);
      check("mid_rst_no_store", {dmem[0], dmem[1]}, {b0, b1});
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_refetch", i_addr, 16'h0002);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
